// File: rtl/sram_fifo_ctrl_if.sv
// Stream and SRAM-strobe bundle for sram_fifo_ctrl.
// The master side is the producer/consumer plus the SRAM macro; the slave side is the controller.
interface sram_fifo_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 4
);
    logic                  push;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  pop;
    logic [DATA_WIDTH-1:0] pop_data;
    logic                  pop_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;
    logic                  mem_fault;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_write_addr;
    logic [DATA_WIDTH-1:0] mem_wr_data;
    logic                  mem_read;
    logic [ADDR_WIDTH-1:0] mem_read_addr;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    logic                  mem_wr_done;
    logic                  mem_rd_done;

    modport master (
        output push, push_data, pop, mem_rd_data, mem_wr_done, mem_rd_done,
        input  pop_data, pop_valid, full, empty, almost_full, count,
               overflow, underflow, mem_fault,
               mem_write, mem_write_addr, mem_wr_data, mem_read, mem_read_addr
    );

    modport slave (
        input  push, push_data, pop, mem_rd_data, mem_wr_done, mem_rd_done,
        output pop_data, pop_valid, full, empty, almost_full, count,
               overflow, underflow, mem_fault,
               mem_write, mem_write_addr, mem_wr_data, mem_read, mem_read_addr
    );
endinterface

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller in front of a single-clock SRAM: pointers, occupancy, status flags,
// one-cycle read return and a sticky check of the SRAM done handshake.
module sram_fifo_ctrl #(
    parameter int unsigned ADDR_WIDTH   = 4,
    parameter int unsigned DATA_WIDTH   = 4,
    parameter int unsigned AFULL_THRESH = 12
) (
    input  logic             clk,
    input  logic             rst,
    sram_fifo_ctrl_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  wr_pend_q, wr_pend_d;
    logic                  rd_pend_q, rd_pend_d;
    logic                  chk_en_q, chk_en_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  mem_fault_q, mem_fault_d;

    logic full_c;
    logic empty_c;
    logic push_acc_c;
    logic pop_acc_c;
    logic pop_valid_c;
    logic hs_err_c;

    // Acceptance from registered status; a pending read is dropped while in reset.
    always_comb begin
        full_c      = (count_q == CNT_W'(DEPTH));
        empty_c     = (count_q == CNT_W'(0));
        push_acc_c  = bus.push & ~full_c;
        pop_acc_c   = bus.pop & ~empty_c;
        pop_valid_c = rd_pend_q & bus.mem_rd_done & ~rst;
        hs_err_c    = chk_en_q & ((bus.mem_wr_done != wr_pend_q) |
                                  (bus.mem_rd_done != rd_pend_q));
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        wr_pend_d   = push_acc_c;
        rd_pend_d   = pop_acc_c;
        chk_en_d    = 1'b1;
        overflow_d  = overflow_q  | (bus.push & full_c);
        underflow_d = underflow_q | (bus.pop & empty_c);
        mem_fault_d = mem_fault_q | hs_err_c;

        if (push_acc_c) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (pop_acc_c) begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        end
        case ({push_acc_c, pop_acc_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            wr_pend_q   <= 1'b0;
            rd_pend_q   <= 1'b0;
            chk_en_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            mem_fault_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            wr_pend_q   <= wr_pend_d;
            rd_pend_q   <= rd_pend_d;
            chk_en_q    <= chk_en_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            mem_fault_q <= mem_fault_d;
        end
    end

    assign bus.full           = full_c;
    assign bus.empty          = empty_c;
    assign bus.almost_full    = (count_q >= CNT_W'(AFULL_THRESH));
    assign bus.count          = count_q;
    assign bus.overflow       = overflow_q;
    assign bus.underflow      = underflow_q;
    assign bus.mem_fault      = mem_fault_q;
    assign bus.pop_valid      = pop_valid_c;
    assign bus.pop_data       = pop_valid_c ? bus.mem_rd_data : DATA_WIDTH'(0);
    assign bus.mem_write      = push_acc_c;
    assign bus.mem_write_addr = wr_ptr_q;
    assign bus.mem_wr_data    = bus.push_data;
    assign bus.mem_read       = pop_acc_c;
    assign bus.mem_read_addr  = rd_ptr_q;
endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Bench for sram_fifo_ctrl: directed scenarios plus random push/pop traffic,
// checked against a queue-based FIFO model and a behavioural SRAM with fault injection.
module tb_sram_fifo_ctrl;
    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 4;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AFULL = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_fifo_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    sram_fifo_ctrl #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .AFULL_THRESH(AFULL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural 16x4 SRAM: data and done flags registered on the request edge.
    logic [DW-1:0] sram [DEPTH];
    logic [DW-1:0] sram_rd_data = '0;
    logic          sram_wr_done = 1'b0;
    logic          sram_rd_done = 1'b0;
    logic          inj_rd_drop  = 1'b0;
    logic          inj_wr_spur  = 1'b0;

    always @(posedge clk) begin
        if (bus.mem_write) sram[bus.mem_write_addr] <= bus.mem_wr_data;
        if (bus.mem_read)  sram_rd_data <= sram[bus.mem_read_addr];
        sram_wr_done <= bus.mem_write;
        sram_rd_done <= bus.mem_read;
    end

    assign bus.mem_rd_data = sram_rd_data;
    assign bus.mem_wr_done = sram_wr_done | inj_wr_spur;
    assign bus.mem_rd_done = sram_rd_done & ~inj_rd_drop;

    // Reference model state
    logic [DW-1:0] mq[$];
    int            m_wr_ptr;
    int            m_rd_ptr;
    bit            m_ovf;
    bit            m_udf;
    bit            m_fault;
    bit            m_mask;
    bit            m_pend_rd;
    bit            m_pend_wr;
    logic [DW-1:0] m_pend_data;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_clear();
        mq.delete();
        m_wr_ptr    = 0;
        m_rd_ptr    = 0;
        m_ovf       = 1'b0;
        m_udf       = 1'b0;
        m_fault     = 1'b0;
        m_mask      = 1'b1;
        m_pend_rd   = 1'b0;
        m_pend_wr   = 1'b0;
        m_pend_data = '0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        #1;
        check_eq("rst_pop_valid", 32'(bus.pop_valid), 0);
        @(posedge clk);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One clock: drive at the falling edge, check mid-cycle, advance the model at the rising edge.
    task automatic cycle(input bit p, input logic [DW-1:0] d, input bit q);
        int sz;
        bit push_ok, pop_ok, exp_pv, nxt_fault;
        bus.push      = p;
        bus.push_data = d;
        bus.pop       = q;
        #1;
        sz      = mq.size();
        push_ok = p && (sz < int'(DEPTH));
        pop_ok  = q && (sz > 0);
        exp_pv  = m_pend_rd && !inj_rd_drop;

        check_eq("count",       32'(bus.count),       sz);
        check_eq("full",        32'(bus.full),        32'(sz == int'(DEPTH)));
        check_eq("empty",       32'(bus.empty),       32'(sz == 0));
        check_eq("almost_full", 32'(bus.almost_full), 32'(sz >= int'(AFULL)));
        check_eq("overflow",    32'(bus.overflow),    32'(m_ovf));
        check_eq("underflow",   32'(bus.underflow),   32'(m_udf));
        check_eq("mem_fault",   32'(bus.mem_fault),   32'(m_fault));
        check_eq("mem_write",   32'(bus.mem_write),   32'(push_ok));
        check_eq("mem_read",    32'(bus.mem_read),    32'(pop_ok));
        check_eq("wr_addr",     32'(bus.mem_write_addr), m_wr_ptr);
        check_eq("rd_addr",     32'(bus.mem_read_addr),  m_rd_ptr);
        if (push_ok) check_eq("wr_data", 32'(bus.mem_wr_data), 32'(d));
        check_eq("pop_valid",   32'(bus.pop_valid),   32'(exp_pv));
        check_eq("pop_data",    32'(bus.pop_data),    exp_pv ? 32'(m_pend_data) : 0);

        nxt_fault = m_fault || (!m_mask && ((inj_rd_drop && m_pend_rd) ||
                                            (inj_wr_spur && !m_pend_wr)));
        @(posedge clk);
        if (pop_ok) begin
            m_pend_data = mq.pop_front();
            m_rd_ptr    = (m_rd_ptr + 1) % int'(DEPTH);
        end
        if (push_ok) begin
            mq.push_back(d);
            m_wr_ptr = (m_wr_ptr + 1) % int'(DEPTH);
        end
        m_pend_rd = pop_ok;
        m_pend_wr = push_ok;
        m_ovf     = m_ovf || (p && sz == int'(DEPTH));
        m_udf     = m_udf || (q && sz == 0);
        m_fault   = nxt_fault;
        m_mask    = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        bus.push      = 1'b0;
        bus.pop       = 1'b0;
        bus.push_data = '0;
        model_clear();
        do_reset();

        // Reset state, then fill 0..F and drain in order
        cycle(1'b0, 4'h0, 1'b0);
        for (int i = 0; i < 16; i++) cycle(1'b1, DW'(i), 1'b0);
        for (int i = 0; i < 16; i++) cycle(1'b0, 4'h0, 1'b1);
        cycle(1'b0, 4'h0, 1'b0);
        check_eq("drain_empty", 32'(bus.empty), 1);

        // Wrap: pointers advance to 10, then concurrent push/pop across the 15->0 boundary
        for (int i = 0; i < 10; i++) cycle(1'b1, DW'($urandom), 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 4'h0, 1'b1);
        cycle(1'b1, 4'h7, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b1, DW'($urandom), 1'b1);
        check_eq("wrap_count", 32'(bus.count), 1);
        cycle(1'b0, 4'h0, 1'b1);
        cycle(1'b0, 4'h0, 1'b0);

        // Push refused while full even with an accepted pop
        do_reset();
        for (int i = 0; i < 16; i++) cycle(1'b1, DW'(15 - i), 1'b0);
        cycle(1'b1, 4'h9, 1'b1);
        cycle(1'b0, 4'h0, 1'b0);
        check_eq("ovf_count", 32'(bus.count), 15);

        // Pop while empty
        do_reset();
        cycle(1'b0, 4'h0, 1'b1);
        cycle(1'b0, 4'h0, 1'b0);
        check_eq("udf_flag", 32'(bus.underflow), 1);

        // Missing rd_done after an accepted pop
        do_reset();
        cycle(1'b1, 4'h5, 1'b0);
        cycle(1'b1, 4'h6, 1'b0);
        cycle(1'b0, 4'h0, 1'b1);
        inj_rd_drop = 1'b1;
        cycle(1'b0, 4'h0, 1'b0);
        inj_rd_drop = 1'b0;
        cycle(1'b0, 4'h0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 4'h0, 1'b0);
        check_eq("fault_sticky", 32'(bus.mem_fault), 1);

        // Spurious wr_done: ignored in the first post-reset cycle, flagged afterwards
        do_reset();
        inj_wr_spur = 1'b1;
        cycle(1'b0, 4'h0, 1'b0);
        inj_wr_spur = 1'b0;
        cycle(1'b0, 4'h0, 1'b0);
        inj_wr_spur = 1'b1;
        cycle(1'b0, 4'h0, 1'b0);
        inj_wr_spur = 1'b0;
        cycle(1'b0, 4'h0, 1'b0);

        // Reset right after a pop with entries queued; the in-flight word is dropped
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, DW'($urandom), 1'b0);
        cycle(1'b0, 4'h0, 1'b1);
        do_reset();
        cycle(1'b0, 4'h0, 1'b0);
        cycle(1'b1, 4'hA, 1'b0);
        cycle(1'b0, 4'h0, 1'b1);
        cycle(1'b0, 4'h0, 1'b0);

        // Random traffic with shifting push/pop bias
        do_reset();
        for (int i = 0; i < 600; i++) begin
            int bias;
            bias = ((i / 100) % 2 == 0) ? 70 : 35;
            cycle(($urandom_range(0, 99) < bias), DW'($urandom),
                  ($urandom_range(0, 99) < (100 - bias)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/sram_fifo_ctrl.md
Name: sram_fifo_ctrl

Overview:
- Synchronous FIFO controller that sits directly upstream of the 16x4 single-clock SRAM macro.
- Converts a push/pop stream interface into the SRAM's write/read/address strobes, and returns read data with a valid flag.
- Maintains the wrap-around pointers, the occupancy count and status flags.
- Checks the SRAM's wr_done/rd_done responses and raises a sticky fault if they are missing or unexpected.

Parameters:
- ADDR_WIDTH, 4, SRAM address width; depth DEPTH = 2**ADDR_WIDTH = 16.
- DATA_WIDTH, 4, data word width in bits (true width, not width-1).
- AFULL_THRESH, 12, count at or above which almost_full asserts.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- push  in  1  write request from producer.
- push_data  in  DATA_WIDTH  word to enqueue.
- pop  in  1  read request from consumer.
- pop_data  out  DATA_WIDTH  dequeued word; meaningful only when pop_valid=1.
- pop_valid  out  1  pop_data valid this cycle.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AFULL_THRESH.
- count  out  ADDR_WIDTH+1  current occupancy, 0..16.
- overflow  out  1  sticky: push attempted while full.
- underflow  out  1  sticky: pop attempted while empty.
- mem_fault  out  1  sticky: SRAM done handshake mismatch.
- mem_write  out  1  to SRAM write.
- mem_write_addr  out  ADDR_WIDTH  to SRAM write_addr.
- mem_wr_data  out  DATA_WIDTH  to SRAM wr_data.
- mem_read  out  1  to SRAM read.
- mem_read_addr  out  ADDR_WIDTH  to SRAM read_addr.
- mem_rd_data  in  DATA_WIDTH  from SRAM rd_data.
- mem_wr_done  in  1  from SRAM wr_done.
- mem_rd_done  in  1  from SRAM rd_done.

Behaviour:
- The SRAM model registers writes, rd_data, wr_done and rd_done on the clock edge where write/read is high. Both done signals are therefore seen exactly one cycle after the request.
- Acceptance rules:
  - push_acc = push & ~full.
  - pop_acc = pop & ~empty.
  - Both are evaluated on the registered full/empty of the current cycle.
  - Push while full is refused even if pop is accepted in the same cycle.
- SRAM drive is combinational from acceptance, in the same cycle:
  - mem_write = push_acc, mem_write_addr = wr_ptr, mem_wr_data = push_data.
  - mem_read = pop_acc, mem_read_addr = rd_ptr.
  - When a request is idle, its address outputs still present the current pointer.
- Pointers are ADDR_WIDTH-bit. They increment on acceptance and wrap 15 -> 0 naturally.
- count update:
  - +1 on push_acc only.
  - -1 on pop_acc only.
  - Unchanged on both or neither.
- full, empty and almost_full are derived from the registered count.
- Read return:
  - rd_pend register is set to pop_acc each cycle.
  - pop_valid = rd_pend & mem_rd_done.
  - pop_data = mem_rd_data when pop_valid, else 0.
  - Pop-to-data latency is exactly 1 cycle; back-to-back pops yield back-to-back valid words.
- Handshake check:
  - wr_pend register is set to push_acc each cycle.
  - mem_fault sets if mem_wr_done != wr_pend or mem_rd_done != rd_pend in any non-reset cycle.
  - Checking is masked in the first cycle after reset deasserts.
- Sticky flags:
  - overflow sets on push & full.
  - underflow sets on pop & empty.
  - overflow, underflow and mem_fault clear only by rst.
- Ordering: strict FIFO. No same-address read/write hazard exists, because a pop requires count>0 and a push requires count<16.
- Reset (any cycle, including mid-operation):
  - Clears wr_ptr, rd_ptr, count, rd_pend, wr_pend and all sticky flags.
  - Reset values: empty=1, full=0, almost_full=0, count=0, pop_valid=0, pop_data=0, mem_write=0, mem_read=0, addresses=0, sticky flags=0.
  - A pop accepted in the cycle before reset produces no pop_valid.
  - SRAM contents are not cleared, and this block does not depend on them.
- Implementation target: 120-250 lines of RTL.

Test Plan:
- Reset, then 16 pushes of data 0x0..0xF -> count steps 1..16; almost_full rises at count 12; full=1 after the 16th; writes appear on mem_write_addr 0..15.
- From full, 16 consecutive pops -> pop_valid high for 16 cycles, each starting one cycle after its pop; pop_data 0x0..0xF in order; empty=1 at the end; pointers back at 0.
- Wrap case: push 10 words, pop 10, push 6 and pop 6 concurrently -> write addresses 10..15 then 0..; read order preserved; count stays constant during the concurrent phase.
- Push while full with pop=1 -> pop accepted, push refused, overflow=1, count=15. Pop while empty -> underflow=1, mem_read=0, no pop_valid.
- Fault injection: force mem_rd_done=0 one cycle after an accepted pop -> pop_valid=0 and mem_fault=1, sticky until rst. Force a spurious mem_wr_done -> mem_fault=1.
- Assert rst in the cycle after a pop with 5 entries queued -> next cycle count=0, empty=1, pop_valid=0, flags=0; a following push+pop returns the newly pushed word.
